// File: rtl/mine_placer.sv
// mine_placer: places a requested number of distinct pseudo-random mines on a 5x5 board
module mine_placer #(
    parameter logic [15:0] SEED      = 16'hACE1,
    parameter int          MAX_MINES = 24
) (
    input  logic        clka,
    input  logic        restart,
    input  logic        start,
    input  logic [4:0]  mines_num,
    output logic [24:0] mines,
    output logic        place_done,
    output logic        busy
);
    typedef enum logic [1:0] {IDLE, CLEAR, PLACE, DONE} state_t;

    // An all-zero seed would lock the LFSR, so fall back to the default seed.
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [4:0]  MAX5     = 5'(MAX_MINES);

    state_t      state, state_nx;
    logic [15:0] lfsr, lfsr_nx;
    logic [4:0]  cnt, target, cand, clamp;
    logic [31:0] mines_ext;
    logic        take, accept;

    assign lfsr_nx    = {1'b0, lfsr[15:1]} ^ (lfsr[0] ? 16'hB400 : 16'h0000);
    assign cand       = lfsr[4:0];
    assign mines_ext  = {7'b0, mines};
    assign accept     = (state == PLACE) && (cand < 5'd25) && !mines_ext[cand];
    assign take       = start && (state == IDLE || state == DONE);
    assign clamp      = (mines_num > MAX5) ? MAX5 : mines_num;
    assign busy       = (state == CLEAR) || (state == PLACE);
    assign place_done = (state == DONE);

    // Next-state decode; starts are only honoured from IDLE or DONE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? CLEAR : IDLE;
            CLEAR:   state_nx = (target == 5'd0) ? DONE : PLACE;
            PLACE:   state_nx = (accept && (cnt + 5'd1 == target)) ? DONE : PLACE;
            DONE:    state_nx = start ? CLEAR : DONE;
            default: state_nx = IDLE;
        endcase
    end

    // State, free-running LFSR, target capture and map build, all on the falling edge.
    always_ff @(negedge clka) begin
        if (restart) begin
            state  <= IDLE;
            mines  <= '0;
            cnt    <= '0;
            target <= '0;
            lfsr   <= SEED_EFF;
        end else begin
            state <= state_nx;
            lfsr  <= lfsr_nx;
            if (take)
                target <= clamp;
            if (state == CLEAR) begin
                mines <= '0;
                cnt   <= '0;
            end else if (accept) begin
                mines <= mines | 25'(32'd1 << cand);
                cnt   <= cnt + 5'd1;
            end
        end
    end
endmodule

// File: tb/tb_mine_placer.sv
// tb_mine_placer: scoreboard bench with a board-level reference model of mine placement
module tb_mine_placer;
    logic        clka = 1'b1;
    logic        restart = 1'b1;
    logic        start = 1'b0;
    logic [4:0]  mines_num = '0;
    logic [24:0] mines;
    logic        place_done, busy;

    typedef struct {
        logic [24:0] map;
        int          cnt;
        int          done_edge;
    } exp_t;

    exp_t        q[$];
    exp_t        e;
    int          total = 0;
    int          bad = 0;
    int          edge_n = 0;
    logic [15:0] m_lfsr = 16'hACE1;
    logic        prev_done = 1'b0;
    logic [24:0] first_map;
    int          k, de;

    mine_placer dut (
        .clka(clka), .restart(restart), .start(start), .mines_num(mines_num),
        .mines(mines), .place_done(place_done), .busy(busy)
    );

    always #5 clka = ~clka;

    function automatic logic [15:0] nxt(input logic [15:0] l);
        return {1'b0, l[15:1]} ^ (l[0] ? 16'hB400 : 16'h0000);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, want);
        end
    endtask

    // Reference LFSR: reloads on restart, otherwise steps every falling edge.
    always @(negedge clka) begin
        edge_n++;
        m_lfsr <= restart ? 16'hACE1 : nxt(m_lfsr);
    end

    // Monitor: each rising place_done is matched against the oldest expected field.
    always @(posedge clka) begin
        if (place_done && !prev_done) begin
            if (q.size() == 0) chk("spurious_done", 1, 0);
            else begin
                e = q.pop_front();
                chk("map", 32'(mines), 32'(e.map));
                chk("popcount", $countones(mines), e.cnt);
                chk("done_edge", edge_n, e.done_edge);
            end
        end
        prev_done = place_done;
    end

    task automatic do_restart(input int n);
        @(posedge clka);
        restart = 1'b1;
        repeat (n) @(posedge clka);
        restart = 1'b0;
        chk("rst_mines", 32'(mines), 0);
        chk("rst_done", 32'(place_done), 0);
        chk("rst_busy", 32'(busy), 0);
    endtask

    // Issue a start and push the field the board rules predict for it.
    task automatic go(input int n, output int ke, output int done_e);
        logic [15:0] l;
        logic [24:0] map;
        int tgt, c, placed;
        @(posedge clka);
        start = 1'b1;
        mines_num = 5'(n);
        @(posedge clka);
        start = 1'b0;
        ke = edge_n;
        l = nxt(m_lfsr);
        tgt = (n > 24) ? 24 : n;
        map = '0;
        c = 0;
        placed = 0;
        while (placed < tgt && c < 65535 * 25) begin
            if (l[4:0] < 25 && !map[l[4:0]]) begin
                map[l[4:0]] = 1'b1;
                placed++;
            end
            c++;
            l = nxt(l);
        end
        done_e = ke + 1 + c;
        q.push_back('{map, tgt, done_e});
    endtask

    task automatic finish_run(input int done_e);
        while (edge_n < done_e + 1) @(posedge clka);
        chk("done_timeout", q.size(), 0);
        q.delete();
        chk("end_done", 32'(place_done), 1);
        chk("end_busy", 32'(busy), 0);
    endtask

    initial begin
        do_restart(2);

        go(0, k, de);
        chk("zero_busy", 32'(busy), 1);
        chk("zero_done_early", 32'(place_done), 0);
        @(posedge clka);
        chk("zero_done", 32'(place_done), 1);
        chk("zero_busy_off", 32'(busy), 0);
        chk("zero_map", 32'(mines), 0);
        finish_run(de);

        go(5, k, de);
        chk("restart_from_done", 32'(place_done), 0);
        chk("busy_from_done", 32'(busy), 1);
        finish_run(de);

        go(31, k, de);
        finish_run(de);
        chk("clamp_zero_bits", 25 - $countones(mines), 1);
        go(25, k, de);
        finish_run(de);

        go(10, k, de);
        repeat (2) @(posedge clka);
        start = 1'b1;
        mines_num = 5'd2;
        @(posedge clka);
        start = 1'b0;
        finish_run(de);
        chk("ignored_start_pop", $countones(mines), 10);
        go(7, k, de);
        chk("rebuild_drop", 32'(place_done), 0);
        finish_run(de);

        go(20, k, de);
        repeat (4) @(posedge clka);
        restart = 1'b1;
        @(posedge clka);
        restart = 1'b0;
        q.delete();
        chk("mid_rst_mines", 32'(mines), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_done", 32'(place_done), 0);

        repeat (3) @(posedge clka);
        go(5, k, de);
        finish_run(de);
        first_map = mines;
        do_restart(2);
        repeat (3) @(posedge clka);
        go(5, k, de);
        finish_run(de);
        chk("repeatable_map", 32'(mines), 32'(first_map));

        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(0, 7)) @(posedge clka);
            go(int'($urandom_range(0, 31)), k, de);
            finish_run(de);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
